// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-side definitions: reset PC, record field widths and the fetch record
// carried from the PC generator to the IF stage.
package fetch_pc_gen_pkg;

    localparam int          PC_W             = 32;
    localparam int          BTB_IDX_W        = 5;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic                 pred_taken;
        logic [PC_W-1:0]      pred_target;
        logic                 btb_hit;
        logic [BTB_IDX_W-1:0] btb_index;
    } fetch_rec_t;

    // Instruction addresses are word aligned; low bits from any source are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_fifo.sv
// Fetch-record queue: power-of-two circular buffer with flush, push, pop and occupancy count.
// Flush and reset both empty the queue and take priority over a same-cycle push/pop.
module fetch_rec_fifo
    import fetch_pc_gen_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_rec_t    push_rec_i,
    input  logic          pop_i,
    output logic          valid_o,
    output fetch_rec_t    head_rec_o,
    output logic [CW-1:0] count_o
);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;
    fetch_rec_t    mem_q [DEPTH];

    assign pop_ok     = pop_i && (count_q != '0);
    assign valid_o    = (count_q != '0);
    assign head_rec_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_ok);
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_i && !reset_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_rec_i;
        end
    end

    // The issuer's credit check must make an enqueue into a full queue impossible.
    always_ff @(posedge clk) begin
        if (!reset_i && !flush_i && push_i) begin
            assert (count_q != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: next-PC selection from redirect / BTB / sequential / hold,
// credit-based issue throttling, and a queue of fetch records for the IF stage.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_pc,
    output logic        fetch_en,
    input  logic [31:0] ret_pc,
    input  logic        taken,
    input  logic        ret_en,
    input  logic [4:0]  ret_index,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_target,
    output logic        out_btb_hit,
    output logic [4:0]  out_btb_index
);

    localparam int          CW           = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(QDEPTH);

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_pc_q, s1_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] next_pc, seq_pc, pred_target;
    logic        pred_taken, issue;
    logic        push, pop, head_valid;
    logic [CW-1:0] count;
    fetch_rec_t  push_rec, head_rec;

    always_comb begin
        seq_pc      = s1_pc_q + 32'd4;
        // A taken prediction is only trusted when the BTB actually hit.
        pred_taken  = taken && ret_en;
        pred_target = pred_taken ? align_pc(ret_pc) : seq_pc;

        if (redirect_en)                   next_pc = align_pc(redirect_pc);
        else if (s1_valid_q && pred_taken) next_pc = align_pc(ret_pc);
        else if (s1_valid_q)               next_pc = seq_pc;
        else                               next_pc = hold_pc_q;

        // The in-flight lookup counts against queue space so a full queue is never overrun.
        issue = !reset && (redirect_en ||
                (({1'b0, count} + (CW+1)'(s1_valid_q)) < CREDIT_LIMIT));

        s1_valid_d = issue;
        s1_pc_d    = issue ? next_pc : s1_pc_q;
        hold_pc_d  = issue ? hold_pc_q : next_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= RESET_PC;
            hold_pc_q  <= RESET_PC;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            hold_pc_q  <= hold_pc_d;
        end
    end

    assign push     = s1_valid_q && !redirect_en;
    assign pop      = head_valid && out_ready && !redirect_en;
    assign push_rec = '{pc: s1_pc_q, pred_taken: pred_taken, pred_target: pred_target,
                        btb_hit: ret_en, btb_index: ret_index};

    fetch_rec_fifo #(.DEPTH(QDEPTH)) u_rec_fifo (
        .clk        (clk),
        .reset_i    (reset),
        .flush_i    (redirect_en),
        .push_i     (push),
        .push_rec_i (push_rec),
        .pop_i      (pop),
        .valid_o    (head_valid),
        .head_rec_o (head_rec),
        .count_o    (count)
    );

    assign fetch_pc        = next_pc;
    assign fetch_en        = issue;
    assign out_valid       = head_valid;
    assign out_pc          = head_rec.pc;
    assign out_pred_taken  = head_rec.pred_taken;
    assign out_pred_target = head_rec.pred_target;
    assign out_btb_hit     = head_rec.btb_hit;
    assign out_btb_index   = head_rec.btb_index;

endmodule
